// File: rtl/duty_phase_filter.sv
// Per-transducer offset stage: adds signed duty/phase offsets to a (duty, phase) stream,
// clamping duty to [0, cycle] and wrapping phase modulo cycle, with a fixed 3-register latency.
module duty_phase_filter #(
    parameter int unsigned WIDTH = 13,
    parameter int unsigned DEPTH = 249
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         din_valid,
    input  logic [DEPTH*(WIDTH+1)-1:0]   filter_duty,
    input  logic [DEPTH*(WIDTH+1)-1:0]   filter_phase,
    input  logic [DEPTH*WIDTH-1:0]       cycle,
    input  logic [WIDTH-1:0]             duty,
    input  logic [WIDTH-1:0]             phase,
    output logic [WIDTH-1:0]             duty_f,
    output logic [WIDTH-1:0]             phase_f,
    output logic                         dout_valid
);

    localparam int unsigned IdxW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned SumW = WIDTH + 2;
    localparam logic [IdxW-1:0] IdxLast = IdxW'(DEPTH - 1);

    logic [IdxW-1:0]         idx_q, idx_d;

    logic [WIDTH-1:0]        duty1_q, duty1_d;
    logic [WIDTH-1:0]        phase1_q, phase1_d;
    logic [IdxW-1:0]         idx1_q, idx1_d;
    logic                    vld1_q, vld1_d;

    logic signed [SumW-1:0]  sd2_q, sd2_d;
    logic signed [SumW-1:0]  sp2_q, sp2_d;
    logic [WIDTH-1:0]        cycle2_q, cycle2_d;
    logic                    vld2_q, vld2_d;

    logic [WIDTH-1:0]        duty_f_q, duty_f_d;
    logic [WIDTH-1:0]        phase_f_q, phase_f_d;
    logic                    vld3_q, vld3_d;

    logic [WIDTH:0]          fd_sel, fp_sel;
    logic signed [SumW-1:0]  duty_ext, phase_ext, fd_ext, fp_ext, cyc_ext, sp_corr;

    // Index restarts on any idle cycle and wraps after the last transducer.
    always_comb begin
        idx_d = idx_q;
        if (!din_valid) begin
            idx_d = '0;
        end else if (idx_q == IdxLast) begin
            idx_d = '0;
        end else begin
            idx_d = idx_q + 1'b1;
        end
    end

    always_comb begin
        duty1_d  = duty;
        phase1_d = phase;
        idx1_d   = idx_q;
        vld1_d   = din_valid;
    end

    always_comb begin
        fd_sel    = filter_duty[idx1_q*(WIDTH+1) +: (WIDTH+1)];
        fp_sel    = filter_phase[idx1_q*(WIDTH+1) +: (WIDTH+1)];
        duty_ext  = $signed({2'b00, duty1_q});
        phase_ext = $signed({2'b00, phase1_q});
        fd_ext    = $signed({fd_sel[WIDTH], fd_sel});
        fp_ext    = $signed({fp_sel[WIDTH], fp_sel});
        sd2_d     = duty_ext + fd_ext;
        sp2_d     = phase_ext + fp_ext;
        cycle2_d  = cycle[idx1_q*WIDTH +: WIDTH];
        vld2_d    = vld1_q;
    end

    // Single conditional correction is exact for phase in [0, cycle) and |offset| <= cycle.
    always_comb begin
        cyc_ext   = $signed({2'b00, cycle2_q});
        sp_corr   = sp2_q;
        duty_f_d  = duty_f_q;
        phase_f_d = phase_f_q;
        vld3_d    = vld2_q;
        if (sp2_q < 0) begin
            sp_corr = sp2_q + cyc_ext;
        end else if (sp2_q >= cyc_ext) begin
            sp_corr = sp2_q - cyc_ext;
        end
        if (vld2_q) begin
            if (sd2_q < 0) begin
                duty_f_d = '0;
            end else if (sd2_q > cyc_ext) begin
                duty_f_d = cycle2_q;
            end else begin
                duty_f_d = sd2_q[WIDTH-1:0];
            end
            phase_f_d = sp_corr[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q     <= '0;
            duty1_q   <= '0;
            phase1_q  <= '0;
            idx1_q    <= '0;
            vld1_q    <= 1'b0;
            sd2_q     <= '0;
            sp2_q     <= '0;
            cycle2_q  <= '0;
            vld2_q    <= 1'b0;
            duty_f_q  <= '0;
            phase_f_q <= '0;
            vld3_q    <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            duty1_q   <= duty1_d;
            phase1_q  <= phase1_d;
            idx1_q    <= idx1_d;
            vld1_q    <= vld1_d;
            sd2_q     <= sd2_d;
            sp2_q     <= sp2_d;
            cycle2_q  <= cycle2_d;
            vld2_q    <= vld2_d;
            duty_f_q  <= duty_f_d;
            phase_f_q <= phase_f_d;
            vld3_q    <= vld3_d;
        end
    end

    assign duty_f     = duty_f_q;
    assign phase_f    = phase_f_q;
    assign dout_valid = vld3_q;

endmodule

// File: tb/tb_duty_phase_filter.sv
// Self-checking bench for duty_phase_filter: directed clamp/wrap cases plus randomized streams
// compared against an arithmetic reference model of the clamp/modulo rules.
module tb_duty_phase_filter;

    localparam int W = 13;
    localparam int D = 249;

    logic                 clk;
    logic                 rst_n;
    logic                 din_valid;
    logic [D*(W+1)-1:0]   filter_duty;
    logic [D*(W+1)-1:0]   filter_phase;
    logic [D*W-1:0]       cycle;
    logic [W-1:0]         duty;
    logic [W-1:0]         phase;
    logic [W-1:0]         duty_f;
    logic [W-1:0]         phase_f;
    logic                 dout_valid;

    int checks;
    int failures;

    int fd_a [D];
    int fp_a [D];
    int cyc_a[D];
    int du_a [D];
    int ph_a [D];

    // Reference model state: per-tick element history and held outputs.
    int m_idx;
    bit pv[3];
    int pd[3];
    int pp[3];
    bit m_ov;
    int m_od;
    int m_op;

    duty_phase_filter #(
        .WIDTH(W),
        .DEPTH(D)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .din_valid    (din_valid),
        .filter_duty  (filter_duty),
        .filter_phase (filter_phase),
        .cycle        (cycle),
        .duty         (duty),
        .phase        (phase),
        .duty_f       (duty_f),
        .phase_f      (phase_f),
        .dout_valid   (dout_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        filter_duty  = '0;
        filter_phase = '0;
        cycle        = '0;
        for (int i = 0; i < D; i++) begin
            filter_duty[i*(W+1) +: (W+1)]  = fd_a[i][W:0];
            filter_phase[i*(W+1) +: (W+1)] = fp_a[i][W:0];
            cycle[i*W +: W]                = cyc_a[i][W-1:0];
        end
    end

    function automatic int ref_duty(input int d, input int o, input int c);
        int s;
        s = d + o;
        if (s < 0) return 0;
        if (s > c) return c;
        return s;
    endfunction

    function automatic int ref_phase(input int p, input int o, input int c);
        return ((p + o) % c + c) % c;
    endfunction

    task automatic model_reset();
        m_idx = 0;
        for (int k = 0; k < 3; k++) begin
            pv[k] = 1'b0;
            pd[k] = 0;
            pp[k] = 0;
        end
        m_ov = 1'b0;
        m_od = 0;
        m_op = 0;
    endtask

    // Drive one cycle of input, advance one clock, and update the model's view of the outputs.
    task automatic tick(input bit v, input int d, input int p);
        int ed;
        int ep;
        din_valid = v;
        duty      = d[W-1:0];
        phase     = p[W-1:0];
        ed = 0;
        ep = 0;
        if (v) begin
            ed = ref_duty(d, fd_a[m_idx], cyc_a[m_idx]);
            ep = ref_phase(p, fp_a[m_idx], cyc_a[m_idx]);
            m_idx = (m_idx == D - 1) ? 0 : m_idx + 1;
        end else begin
            m_idx = 0;
        end
        @(posedge clk);
        #1;
        pv[2] = pv[1]; pd[2] = pd[1]; pp[2] = pp[1];
        pv[1] = pv[0]; pd[1] = pd[0]; pp[1] = pp[0];
        pv[0] = v;     pd[0] = ed;    pp[0] = ep;
        m_ov = pv[2];
        if (pv[2]) begin
            m_od = pd[2];
            m_op = pp[2];
        end
    endtask

    task automatic randomize_tables(input bit zero_offsets);
        for (int i = 0; i < D; i++) begin
            cyc_a[i] = int'($urandom_range(8000, 2000));
            fd_a[i]  = zero_offsets ? 0 : int'($urandom_range(2 * cyc_a[i], 0)) - cyc_a[i];
            fp_a[i]  = zero_offsets ? 0 : int'($urandom_range(2 * cyc_a[i], 0)) - cyc_a[i];
            du_a[i]  = int'($urandom_range(cyc_a[i] / 2, 0));
            ph_a[i]  = int'($urandom_range(cyc_a[i] - 1, 0));
        end
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        din_valid = 1'b0;
        duty      = '0;
        phase     = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({dout_valid, duty_f, phase_f} !== {1'b0, {W{1'b0}}, {W{1'b0}}}) begin
            failures++;
            $display("FAIL reset_state got v=%0b d=%0d p=%0d want v=0 d=0 p=0",
                     dout_valid, duty_f, phase_f);
        end
        rst_n = 1'b1;
        tick(1'b0, 0, 0);
    endtask

    task automatic test_clamp();
        int exp_d[4] = '{4096, 0, 4096, 0};
        int offs[4]  = '{4096, -4096, 2048, -2048};
        int k;
        for (int i = 0; i < D; i++) begin
            cyc_a[i] = 4096;
            fd_a[i]  = 0;
            fp_a[i]  = 0;
        end
        for (int i = 0; i < 4; i++) fd_a[i] = offs[i];
        k = 0;
        for (int t = 0; t < 8; t++) begin
            tick(t < 4, 2048, 0);
            checks++;
            if ({dout_valid, duty_f, phase_f} !== {m_ov, m_od[W-1:0], m_op[W-1:0]}) begin
                failures++;
                $display("FAIL clamp_model t=%0d got v=%0b d=%0d p=%0d want v=%0b d=%0d p=%0d",
                         t, dout_valid, duty_f, phase_f, m_ov, m_od, m_op);
            end
            if (dout_valid === 1'b1 && k < 4) begin
                checks++;
                if (duty_f !== exp_d[k][W-1:0]) begin
                    failures++;
                    $display("FAIL clamp_case k=%0d got duty_f=%0d want %0d", k, duty_f, exp_d[k]);
                end
                k++;
            end
        end
        checks++;
        if (k != 4) begin
            failures++;
            $display("FAIL clamp_count got %0d valid outputs want 4", k);
        end
    endtask

    task automatic test_wrap();
        int offs[4] = '{4096, -4096, 2048, -2048};
        int exp_p[4] = '{2048, 2048, 0, 0};
        int k;
        for (int i = 0; i < D; i++) begin
            cyc_a[i] = 4096;
            fd_a[i]  = 0;
            fp_a[i]  = 0;
        end
        for (int i = 0; i < 4; i++) fp_a[i] = offs[i];
        k = 0;
        for (int t = 0; t < 8; t++) begin
            tick(t < 4, 100, 2048);
            checks++;
            if ({dout_valid, duty_f, phase_f} !== {m_ov, m_od[W-1:0], m_op[W-1:0]}) begin
                failures++;
                $display("FAIL wrap_model t=%0d got v=%0b d=%0d p=%0d want v=%0b d=%0d p=%0d",
                         t, dout_valid, duty_f, phase_f, m_ov, m_od, m_op);
            end
            if (dout_valid === 1'b1 && k < 4) begin
                checks++;
                if (phase_f !== exp_p[k][W-1:0]) begin
                    failures++;
                    $display("FAIL wrap_case k=%0d got phase_f=%0d want %0d", k, phase_f, exp_p[k]);
                end
                k++;
            end
        end
        checks++;
        if (k != 4) begin
            failures++;
            $display("FAIL wrap_count got %0d valid outputs want 4", k);
        end
    endtask

    task automatic test_random();
        int nvalid;
        for (int s = 0; s < 100; s++) begin
            randomize_tables(1'b0);
            nvalid = 0;
            for (int t = 0; t < D + 4; t++) begin
                if (t < D) tick(1'b1, du_a[t], ph_a[t]);
                else tick(1'b0, 0, 0);
                if (dout_valid === 1'b1) nvalid++;
                checks++;
                if ({dout_valid, duty_f, phase_f} !== {m_ov, m_od[W-1:0], m_op[W-1:0]}) begin
                    failures++;
                    $display("FAIL random s=%0d t=%0d got v=%0b d=%0d p=%0d want v=%0b d=%0d p=%0d",
                             s, t, dout_valid, duty_f, phase_f, m_ov, m_od, m_op);
                end
            end
            checks++;
            if (nvalid != D) begin
                failures++;
                $display("FAIL random_valid_count s=%0d got %0d want %0d", s, nvalid, D);
            end
        end
    endtask

    task automatic test_disabled();
        int q_d[$];
        int q_p[$];
        int ed;
        int ep;
        randomize_tables(1'b1);
        for (int i = 0; i < D; i++) du_a[i] = int'($urandom_range(cyc_a[i], 0));
        for (int t = 0; t < D + 4; t++) begin
            if (t < D) begin
                q_d.push_back(du_a[t]);
                q_p.push_back(ph_a[t]);
                tick(1'b1, du_a[t], ph_a[t]);
            end else begin
                tick(1'b0, 0, 0);
            end
            if (dout_valid === 1'b1 && q_d.size() > 0) begin
                ed = q_d.pop_front();
                ep = q_p.pop_front();
                checks++;
                if (duty_f !== ed[W-1:0] || phase_f !== ep[W-1:0]) begin
                    failures++;
                    $display("FAIL passthrough t=%0d got d=%0d p=%0d want d=%0d p=%0d",
                             t, duty_f, phase_f, ed, ep);
                end
            end
        end
        checks++;
        if (q_d.size() != 0) begin
            failures++;
            $display("FAIL passthrough_count got %0d missing outputs want 0", q_d.size());
        end
    endtask

    task automatic test_reset_mid_stream();
        randomize_tables(1'b0);
        for (int t = 0; t < 100; t++) begin
            tick(1'b1, du_a[t], ph_a[t]);
            checks++;
            if ({dout_valid, duty_f, phase_f} !== {m_ov, m_od[W-1:0], m_op[W-1:0]}) begin
                failures++;
                $display("FAIL pre_reset t=%0d got v=%0b d=%0d p=%0d want v=%0b d=%0d p=%0d",
                         t, dout_valid, duty_f, phase_f, m_ov, m_od, m_op);
            end
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({dout_valid, duty_f, phase_f} !== {1'b0, {W{1'b0}}, {W{1'b0}}}) begin
            failures++;
            $display("FAIL async_reset got v=%0b d=%0d p=%0d want v=0 d=0 p=0",
                     dout_valid, duty_f, phase_f);
        end
        model_reset();
        din_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        randomize_tables(1'b0);
        for (int t = 0; t < D + 5; t++) begin
            if (t >= 1 && t <= D) tick(1'b1, du_a[t-1], ph_a[t-1]);
            else tick(1'b0, 0, 0);
            checks++;
            if ({dout_valid, duty_f, phase_f} !== {m_ov, m_od[W-1:0], m_op[W-1:0]}) begin
                failures++;
                $display("FAIL post_reset t=%0d got v=%0b d=%0d p=%0d want v=%0b d=%0d p=%0d",
                         t, dout_valid, duty_f, phase_f, m_ov, m_od, m_op);
            end
        end
    endtask

    task automatic test_back_to_back();
        randomize_tables(1'b0);
        for (int t = 0; t < 2 * D + 5; t++) begin
            if (t < D) tick(1'b1, du_a[t], ph_a[t]);
            else if (t == D) tick(1'b0, 0, 0);
            else if (t <= 2 * D) tick(1'b1, du_a[t-D-1], ph_a[t-D-1]);
            else tick(1'b0, 0, 0);
            checks++;
            if ({dout_valid, duty_f, phase_f} !== {m_ov, m_od[W-1:0], m_op[W-1:0]}) begin
                failures++;
                $display("FAIL back_to_back t=%0d got v=%0b d=%0d p=%0d want v=%0b d=%0d p=%0d",
                         t, dout_valid, duty_f, phase_f, m_ov, m_od, m_op);
            end
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        rst_n     = 1'b0;
        din_valid = 1'b0;
        duty      = '0;
        phase     = '0;
        for (int i = 0; i < D; i++) begin
            fd_a[i]  = 0;
            fp_a[i]  = 0;
            cyc_a[i] = 4096;
            du_a[i]  = 0;
            ph_a[i]  = 0;
        end
        test_reset();
        test_clamp();
        test_wrap();
        test_random();
        test_disabled();
        test_reset_mid_stream();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/duty_phase_filter.md
Name: duty_phase_filter

Overview:
- Per-transducer offset stage in the FPGA PWM data path.
- Consumes a stream of DEPTH (duty, phase) pairs, one per clock, in transducer order.
- Adds a signed per-transducer duty offset and a signed per-transducer phase offset to each pair.
- Duty result is clamped to [0, CYCLE[i]]; phase result wraps modulo CYCLE[i]. The resulting stream goes to the PWM generator.

Parameters:
- WIDTH, 13, bit width of duty/phase/cycle values (unsigned); offsets are WIDTH+1 bits signed.
- DEPTH, 249, number of transducers (stream length and array depth).

Ports:
- CLK  in  1  system clock (20.48 MHz domain).
- RST_N  in  1  asynchronous active-low reset.
- DIN_VALID  in  1  high for each cycle carrying a valid input element.
- FILTER_DUTY  in  DEPTH x (WIDTH+1) signed  per-transducer duty offset, range [-CYCLE[i], CYCLE[i]].
- FILTER_PHASE  in  DEPTH x (WIDTH+1) signed  per-transducer phase offset, range [-CYCLE[i], CYCLE[i]].
- CYCLE  in  DEPTH x WIDTH  per-transducer period, 2000..8000 in normal use.
- DUTY  in  WIDTH  input duty for the current element.
- PHASE  in  WIDTH  input phase for the current element, range [0, CYCLE[i]-1].
- DUTY_F  out  WIDTH  filtered duty.
- PHASE_F  out  WIDTH  filtered phase.
- DOUT_VALID  out  1  high for each cycle carrying a valid output element.

Behaviour:
- Reset (async, RST_N low): DUTY_F=0, PHASE_F=0, DOUT_VALID=0.
  - Input index counter is cleared to 0.
  - All pipeline valid bits are cleared.
- Input indexing: an internal counter idx (ceil(log2 DEPTH) bits) selects element i.
  - The element sampled on a rising edge with DIN_VALID=1 uses idx as i; idx then increments.
  - Any cycle with DIN_VALID=0 resets idx to 0.
  - A stream is DEPTH consecutive DIN_VALID cycles. If more than DEPTH arrive back-to-back, idx wraps to 0 after DEPTH-1.
- Pipeline: fixed latency of 3 clock cycles from the input sample edge to the output edge.
  - Stage 1: register DUTY, PHASE, idx, valid.
  - Stage 2: form signed sums using WIDTH+2-bit signed arithmetic, and register CYCLE[idx]:
    - sd = DUTY + FILTER_DUTY[idx]
    - sp = PHASE + FILTER_PHASE[idx]
  - Stage 3: correct, register to outputs.
  - DOUT_VALID is DIN_VALID delayed by exactly 3 cycles.
  - Input gaps are reproduced as output gaps: output element k appears exactly 3 cycles after input element k.
- Duty rule: DUTY_F = 0 if sd<0; CYCLE[i] if sd>CYCLE[i]; else sd.
- Phase rule: PHASE_F = (PHASE + FILTER_PHASE[i] + CYCLE[i]) mod CYCLE[i], implemented as a single conditional correction:
  - sp<0 -> sp+CYCLE[i]
  - sp>=CYCLE[i] -> sp-CYCLE[i]
  - else sp
  - This is exact for PHASE in [0,CYCLE-1] and offset in [-CYCLE,CYCLE]. Behaviour outside those ranges is don't-care but must not hang.
- Zero offsets: outputs equal inputs exactly (pass-through).
- When DOUT_VALID=0, DUTY_F/PHASE_F hold their last value.
- Offsets and CYCLE are sampled combinationally by index. They must be stable from the first DIN_VALID of a stream until its last output.
- Reset mid-stream: the pipeline is flushed; no DOUT_VALID until a new stream is input.

Test Plan:
- Clamp cases, CYCLE=4096 for all, DUTY=2048, one element per offset:
  - FILTER_DUTY=+4096 -> DUTY_F=4096
  - FILTER_DUTY=-4096 -> DUTY_F=0
  - FILTER_DUTY=+2048 -> DUTY_F=4096
  - FILTER_DUTY=-2048 -> DUTY_F=0
- Wrap cases, CYCLE=4096, PHASE=2048, one element per offset:
  - FILTER_PHASE=+4096 -> PHASE_F=2048
  - FILTER_PHASE=-4096 -> PHASE_F=2048
  - FILTER_PHASE=+2048 -> PHASE_F=0
  - FILTER_PHASE=-2048 -> PHASE_F=0
- Random: 100 streams of DEPTH elements with:
  - CYCLE in [2000,8000]
  - offsets in [-CYCLE,CYCLE]
  - DUTY in [0,CYCLE/2]
  - PHASE in [0,CYCLE-1]
  - -> every output matches the clamp/modulo rules in index order.
  - -> DOUT_VALID is high for exactly DEPTH cycles, starting 3 cycles after the first DIN_VALID.
- Disabled filter: all offsets 0, random CYCLE/DUTY/PHASE -> DUTY_F==DUTY and PHASE_F==PHASE per element.
- Reset: assert RST_N low mid-stream -> DOUT_VALID=0 and outputs 0 immediately. Next full stream -> indices restart at 0 and outputs are correct.
- Back-to-back streams separated by one DIN_VALID=0 cycle -> second stream is indexed from 0 and is correct.
